// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, address type and x0 constant for regfile_sb
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with flush > set > clear priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_next;

    // A new producer issued on the same edge as the old one's write-back wins.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (clr_en) begin
                busy_next[clr_addr] = 1'b0;
            end
            if (set_en && (set_addr != AW'(REG_ZERO))) begin
                busy_next[set_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    input  logic                flush,
    output logic [NREGS-1:0]    busy
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_hit;

    assign wr_hit = wr_en && (wr_addr != AW'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue_en),
        .set_addr (issue_addr),
        .clr_en   (wr_hit),
        .clr_addr (wr_addr),
        .flush    (flush),
        .busy     (busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            ready;

        assign addr = rd_addr[i*AW +: AW];

        // Disabled ports and x0 read as zero and never stall decode.
        always_comb begin
            data  = '0;
            ready = 1'b1;
            if (rd_en[i] && (addr != AW'(REG_ZERO))) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_hit && (addr == wr_addr)) begin
                    data  = wr_data;
                    ready = 1'b1;
                end else begin
                    data  = regs[addr];
                    ready = !busy[addr];
                end
`else
                data  = regs[addr];
                ready = !busy[addr];
`endif
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_ready[i]             = ready;
    end

endmodule
